// File: rtl/maze_pkg.sv
// Shared types and constants for the maze-solver sequencing FSM.
package maze_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StMark,
      StCheck,
      StMove,
      StBack,
      StDone,
      StFail
   } stateT;

   // Move directions as driven on dir.
   localparam logic [1:0] DIR_UP    = 2'b00;  // y-1
   localparam logic [1:0] DIR_RIGHT = 2'b01;  // x+1
   localparam logic [1:0] DIR_LEFT  = 2'b10;  // x-1
   localparam logic [1:0] DIR_DOWN  = 2'b11;  // y+1

   localparam logic [7:0]  DEFAULT_GOAL      = 8'hFF;
   localparam logic [15:0] DEFAULT_MAX_STEPS = 16'd1024;

endpackage

// File: rtl/maze_controller.sv
// Depth-first maze walk sequencer: scans the four directions of the current
// cell, moves into the first open one (pushing the old location), backtracks
// through the location stack at dead ends, and stops on goal, empty stack or
// watchdog expiry.
module maze_controller
   import maze_pkg::*;
#(
   parameter logic [7:0]  GOAL      = DEFAULT_GOAL,
   parameter logic [15:0] MAX_STEPS = DEFAULT_MAX_STEPS  // 0 disables the watchdog
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        cntReach,
   input  logic        empStck,
   input  logic        wall,
   input  logic [7:0]  curLoc,
   output logic [1:0]  dir,
   output logic        rgLd,
   output logic        push,
   output logic        pop,
   output logic        readFromStack,
   output logic        memWr,
   output logic        memAddrSel,
   output logic        done,
   output logic        fail,
   output logic [15:0] steps
);

   stateT       stateQ;
   logic [1:0]  dirQ;
   logic [15:0] stepsQ;

   logic rejected;
   logic watchdogHit;

   // wall is meaningless when the move leaves the grid (the address wraps),
   // but OR-ing is still correct since cntReach alone forces rejection.
   assign rejected    = cntReach | wall;
   assign watchdogHit = (MAX_STEPS != 16'd0) && (stepsQ == MAX_STEPS);

   // State, direction register and saturating step counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= StIdle;
         dirQ   <= DIR_UP;
         stepsQ <= 16'd0;
      end else begin
         unique case (stateQ)
            StIdle: begin
               if (start) begin
                  stateQ <= StMark;
                  dirQ   <= DIR_UP;
                  stepsQ <= 16'd0;
               end
            end
            StMark: begin
               if (curLoc == GOAL) begin
                  stateQ <= StDone;
               end else if (watchdogHit) begin
                  stateQ <= StFail;
               end else begin
                  dirQ   <= DIR_UP;
                  stateQ <= StCheck;
               end
            end
            StCheck: begin
               if (rejected) begin
                  if (dirQ != DIR_DOWN) begin
                     dirQ <= dirQ + 2'd1;
                  end else begin
                     stateQ <= StBack;
                  end
               end else begin
                  stateQ <= StMove;
               end
            end
            StMove: begin
               if (stepsQ != 16'hFFFF) begin
                  stepsQ <= stepsQ + 16'd1;
               end
               stateQ <= StMark;
            end
            StBack: begin
               stateQ <= empStck ? StFail : StMark;
            end
            StDone: stateQ <= StDone;
            StFail: stateQ <= StFail;
            default: stateQ <= StIdle;
         endcase
      end
   end

   // Output decode from the registered state; BACK suppresses its stack pop
   // when there is nothing left to pop.
   always_comb begin
      dir           = 2'b00;
      rgLd          = 1'b0;
      push          = 1'b0;
      pop           = 1'b0;
      readFromStack = 1'b0;
      memWr         = 1'b0;
      memAddrSel    = 1'b0;
      done          = 1'b0;
      fail          = 1'b0;
      unique case (stateQ)
         StIdle: ;
         StMark: begin
            memWr      = 1'b1;
            memAddrSel = 1'b1;
         end
         StCheck: begin
            dir = dirQ;
         end
         StMove: begin
            dir  = dirQ;
            push = 1'b1;
            rgLd = 1'b1;
         end
         StBack: begin
            if (!empStck) begin
               pop           = 1'b1;
               readFromStack = 1'b1;
               rgLd          = 1'b1;
            end
         end
         StDone: done = 1'b1;
         StFail: fail = 1'b1;
         default: ;
      endcase
   end

   assign steps = stepsQ;

endmodule

// File: tb/tb_maze_controller.sv
// Directed-vector bench for maze_controller.
module tb_maze_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        cntReach = 1'b0;
   logic        empStck = 1'b0;
   logic        wall = 1'b0;
   logic [7:0]  curLoc = 8'h00;
   logic [1:0]  dir;
   logic        rgLd, push, pop, readFromStack, memWr, memAddrSel, done, fail;
   logic [15:0] steps;

   int errors = 0;
   int checks = 0;

   maze_controller #(
      .GOAL      (8'hFF),
      .MAX_STEPS (16'd4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .cntReach      (cntReach),
      .empStck       (empStck),
      .wall          (wall),
      .curLoc        (curLoc),
      .dir           (dir),
      .rgLd          (rgLd),
      .push          (push),
      .pop           (pop),
      .readFromStack (readFromStack),
      .memWr         (memWr),
      .memAddrSel    (memAddrSel),
      .done          (done),
      .fail          (fail),
      .steps         (steps)
   );

   always #5 clk = ~clk;

   // Output bundle: {dir, rgLd, push, pop, readFromStack, memWr, memAddrSel, done, fail}
   logic [9:0] outs;
   assign outs = {dir, rgLd, push, pop, readFromStack, memWr, memAddrSel, done, fail};

   localparam logic [9:0] O_IDLE = 10'b00_0000_0000;
   localparam logic [9:0] O_MARK = 10'b00_0000_1100;
   localparam logic [9:0] O_BACK = 10'b00_1011_0000;
   localparam logic [9:0] O_DONE = 10'b00_0000_0010;
   localparam logic [9:0] O_FAIL = 10'b00_0000_0001;

   function automatic logic [9:0] oCheck(input logic [1:0] d);
      return {d, 8'b0000_0000};
   endfunction

   function automatic logic [9:0] oMove(input logic [1:0] d);
      return {d, 8'b1100_0000};
   endfunction

   typedef struct {
      logic        r;
      logic        s;
      logic        cr;
      logic        es;
      logic        w;
      logic [7:0]  loc;
      logic [9:0]  expOuts;
      logic [15:0] expSteps;
   } vecT;

   function automatic vecT mk(input logic r, input logic s, input logic cr, input logic es,
                              input logic w, input logic [7:0] loc, input logic [9:0] eo,
                              input logic [15:0] est);
      vecT v;
      v.r = r; v.s = s; v.cr = cr; v.es = es; v.w = w; v.loc = loc;
      v.expOuts = eo; v.expSteps = est;
      return v;
   endfunction

   // Drive inputs, clock once, then sample just after the edge.
   task automatic step(input vecT v, input string nm);
      rst = v.r; start = v.s; cntReach = v.cr; empStck = v.es; wall = v.w; curLoc = v.loc;
      @(posedge clk);
      #1;
      checks++;
      if (outs !== v.expOuts) begin
         errors++;
         $display("FAIL %s outs got=%b exp=%b", nm, outs, v.expOuts);
      end
      checks++;
      if (steps !== v.expSteps) begin
         errors++;
         $display("FAIL %s steps got=%0d exp=%0d", nm, steps, v.expSteps);
      end
      checks++;
      if (push && pop) begin
         errors++;
         $display("FAIL %s push_pop got=11 exp=not both", nm);
      end
   endtask

   vecT tbl[26];

   initial begin
      //             rst st cr es w  loc    outs            steps
      tbl[0]  = mk(1, 1, 0, 0, 0, 8'h00, O_IDLE,         16'd0);  // start during rst ignored
      tbl[1]  = mk(1, 0, 0, 0, 0, 8'h00, O_IDLE,         16'd0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 8'h00, O_IDLE,         16'd0);
      tbl[3]  = mk(0, 1, 0, 0, 0, 8'h00, O_MARK,         16'd0);  // first move
      tbl[4]  = mk(0, 0, 0, 0, 0, 8'h00, oCheck(2'b00),  16'd0);
      tbl[5]  = mk(0, 0, 1, 0, 0, 8'h00, oCheck(2'b01),  16'd0);  // off-grid up rejected
      tbl[6]  = mk(0, 0, 0, 0, 0, 8'h00, oMove(2'b01),   16'd0);  // right accepted
      tbl[7]  = mk(0, 0, 0, 0, 0, 8'h10, O_MARK,         16'd1);
      tbl[8]  = mk(0, 0, 0, 0, 1, 8'h10, oCheck(2'b00),  16'd1);  // dead end, stack non-empty
      tbl[9]  = mk(0, 0, 0, 0, 1, 8'h10, oCheck(2'b01),  16'd1);
      tbl[10] = mk(0, 0, 0, 0, 1, 8'h10, oCheck(2'b10),  16'd1);
      tbl[11] = mk(0, 0, 0, 0, 1, 8'h10, oCheck(2'b11),  16'd1);
      tbl[12] = mk(0, 0, 0, 0, 1, 8'h10, O_BACK,         16'd1);
      tbl[13] = mk(0, 0, 0, 0, 0, 8'h00, O_MARK,         16'd1);
      tbl[14] = mk(0, 0, 0, 0, 1, 8'h00, oCheck(2'b00),  16'd1);  // dead end, stack empty
      tbl[15] = mk(0, 0, 0, 0, 1, 8'h00, oCheck(2'b01),  16'd1);
      tbl[16] = mk(0, 0, 0, 0, 1, 8'h00, oCheck(2'b10),  16'd1);
      tbl[17] = mk(0, 0, 0, 0, 1, 8'h00, oCheck(2'b11),  16'd1);
      tbl[18] = mk(0, 0, 0, 1, 1, 8'h00, O_IDLE,         16'd1);  // BACK with empty stack: no pop
      tbl[19] = mk(0, 0, 0, 1, 0, 8'h00, O_FAIL,         16'd1);
      tbl[20] = mk(0, 1, 0, 1, 0, 8'h00, O_FAIL,         16'd1);  // start ignored, fail sticky
      tbl[21] = mk(0, 0, 0, 1, 0, 8'h00, O_FAIL,         16'd1);
      tbl[22] = mk(1, 0, 0, 0, 0, 8'h00, O_IDLE,         16'd0);  // goal
      tbl[23] = mk(0, 1, 0, 0, 0, 8'hFF, O_MARK,         16'd0);
      tbl[24] = mk(0, 0, 0, 0, 0, 8'hFF, O_DONE,         16'd0);
      tbl[25] = mk(0, 1, 0, 0, 0, 8'hFF, O_DONE,         16'd0);

      for (int i = 0; i < 26; i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
      end

      // Reset mid-solve aborts while in MOVE: no step credited, no further push.
      step(mk(1, 0, 0, 0, 0, 8'h00, O_IDLE,        16'd0), "abort_rst");
      step(mk(0, 1, 0, 0, 0, 8'h00, O_MARK,        16'd0), "abort_mark");
      step(mk(0, 0, 0, 0, 0, 8'h00, oCheck(2'b00), 16'd0), "abort_check");
      step(mk(0, 0, 0, 0, 0, 8'h00, oMove(2'b00),  16'd0), "abort_move");
      step(mk(1, 1, 0, 0, 0, 8'h00, O_IDLE,        16'd0), "abort_hit");
      step(mk(0, 0, 0, 0, 0, 8'h00, O_IDLE,        16'd0), "abort_idle");

      // Watchdog with MAX_STEPS=4 and every cell open.
      step(mk(0, 1, 0, 0, 0, 8'h00, O_MARK, 16'd0), "wd_start");
      for (int i = 1; i <= 4; i++) begin
         step(mk(0, 0, 0, 0, 0, 8'h00, oCheck(2'b00), 16'(i - 1)), $sformatf("wd_check%0d", i));
         step(mk(0, 0, 0, 0, 0, 8'h00, oMove(2'b00),  16'(i - 1)), $sformatf("wd_move%0d", i));
         step(mk(0, 0, 0, 0, 0, 8'h00, O_MARK,        16'(i)),     $sformatf("wd_mark%0d", i));
      end
      step(mk(0, 0, 0, 0, 0, 8'h00, O_FAIL, 16'd4), "wd_fail");
      step(mk(0, 1, 0, 0, 0, 8'h00, O_FAIL, 16'd4), "wd_fail_hold");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
